seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-division scan controller that shares the single active-low segment bus (nSEG) among four common-anode digits (nAN).
- Accepts four BCD/hex nibbles and four decimal-point flags from the counter datapath (seconds, tens, minutes).
- Latches them once per frame so a frame never shows a mix of old and new values.
- Drives one digit at a time, with a programmable blanking gap before each digit to suppress ghosting, plus optional leading-zero suppression.

Parameters:
SCAN_DIV, 100000, CLK100 cycles per digit slot (1 kHz slot rate, 250 Hz frame rate); must be >= 2.
BLANK, 1000, cycles at the start of each slot with all anodes off; 0 <= BLANK < SCAN_DIV.

Ports:
CLK100  in  1  system clock, 100 MHz
RST  in  1  reset, synchronous, active-high
DIGITS  in  16  digit values; [3:0] = digit0 (rightmost, nAN[0]) ... [15:12] = digit3 (leftmost, nAN[3])
DP_IN  in  4  decimal point request per digit, 1 = lit; bit i belongs to digit i
LZ_EN  in  1  1 = suppress leading zeros
nSEG  out  8  segments, active-low; [7] = dp, [6:0] = gfedcba
nAN  out  4  anode enables, active-low, at most one bit low at any time
FRAME  out  1  one-cycle pulse marking each shadow-register load (start of slot 0)

Behaviour:
- Reset (RST=1 at a CLK100 edge), synchronous, wins over everything:
  - slot counter cnt=0, digit index idx=0, shadow regs (digits, dp, lz)=0.
  - nSEG=8'hFF, nAN=4'b1111, FRAME=0.
- Slot counter:
  - cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - At the wrap, idx advances 0->1->2->3->0.
  - Width is ceil(log2(SCAN_DIV)); idx is 2 bits.
- Shadow load:
  - Occurs in any cycle where cnt==0 and idx==0, including the first cycle after RST deasserts.
  - Captures DIGITS, DP_IN and LZ_EN; FRAME=1 is registered from the same condition, so it is high in the cycle after the load cycle.
  - Input changes at any other time have no visible effect until the next load.
- Output pipeline:
  - nSEG/nAN/FRAME are registered.
  - Values reflect the (cnt, idx, shadow) state of the preceding cycle, i.e. 1-cycle latency.
- Blank phase (cnt < BLANK): nAN=1111, nSEG=FF.
  - BLANK=0 means no blank phase.
- Drive phase (cnt >= BLANK):
  - nAN has only bit idx low.
  - nSEG = {~dp[idx], seg(shadow digit idx)}.
- Segment decode (gfedcba, 0 = lit):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0010000
  - Codes 10..15 decode to 1111111 (blank); dp is still honoured.
- Leading-zero suppression (only when shadow lz=1):
  - digit3 is blanked if it is 0.
  - digit2 is blanked if digit3 and digit2 are both 0.
  - digit1 is blanked if digits 3..1 are all 0.
  - digit0 is never blanked.
  - A blanked digit outputs segments 1111111; its dp still follows dp[idx].
  - Its anode is still driven, to keep duty cycle uniform.
- Invariants:
  - nAN never has more than one bit low.
  - Exactly one FRAME pulse per 4*SCAN_DIV cycles.
- Reset mid-slot: outputs return to blank on the next cycle and scanning restarts from idx=0 with a fresh shadow load.

Test Plan:
1. Reset/first frame (SCAN_DIV=8, BLANK=2):
   - Hold RST 3 cycles -> nAN=1111, nSEG=FF throughout.
   - After release, FRAME pulses on cycle 1.
   - nAN=1111 for cycles 1-2, then 1110 for cycles 3-8.
2. Full scan (SCAN_DIV=8, BLANK=2):
   - DIGITS=16'h1234, DP_IN=0100, LZ_EN=0 -> slots show 4 (nSEG=10011001), 3 (10110000), 2 with dp (00100100), 1 (11111001).
   - Each is on nAN 1110/1101/1011/0111 respectively.
   - FRAME repeats every 32 cycles.
3. Leading zeros: DIGITS=16'h0005, LZ_EN=1 -> digits 3..1 show nSEG=11111111 with anodes still cycling; digit0 shows 10010010. Same with LZ_EN=0 -> digits 3..1 show 11000000.
4. Frame coherency: change DIGITS from 16'h0009 to 16'h0010 while idx=2 -> remaining slots of that frame still show old values; new values appear only after the next FRAME pulse.
5. Invalid codes and BLANK=0: DIGITS=16'hABCD, DP_IN=1111 -> every slot nSEG=01111111. With BLANK=0, anodes are active from cnt=0 and no all-off cycles appear.
6. Mid-slot reset: assert RST at idx=3, cnt=5 -> next cycle nAN=1111. After release, scanning restarts at digit0 with a FRAME pulse, and the one-hot-low anode invariant holds across the whole run.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-division scan controller for four common-anode 7-segment digits
//   that share one active-low segment bus. Digit values, decimal points and
//   the leading-zero enable are captured into shadow registers once per frame
//   (at the start of slot 0), so a frame never mixes old and new values.
//   Each digit slot lasts SCAN_DIV cycles. The first BLANK cycles of a slot
//   keep all anodes off to suppress ghosting.
//
// Parameters:
//   SCAN_DIV  CLK100 cycles per digit slot (>= 2)
//   BLANK     all-anodes-off cycles at the start of each slot (< SCAN_DIV)
//
// Ports:
//   CLK100  in   system clock
//   RST     in   synchronous, active-high reset
//   DIGITS  in   [3:0]=digit0 (rightmost) ... [15:12]=digit3 (leftmost)
//   DP_IN   in   decimal point request, bit i = digit i, 1 = lit
//   LZ_EN   in   1 = suppress leading zeros
//   nSEG    out  segments, active-low, [7]=dp, [6:0]=gfedcba
//   nAN     out  anode enables, active-low, at most one low
//   FRAME   out  one-cycle pulse following each shadow-register load
module seg7_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned BLANK    = 1000
) (
    input  logic        CLK100,
    input  logic        RST,
    input  logic [15:0] DIGITS,
    input  logic [3:0]  DP_IN,
    input  logic        LZ_EN,
    output logic [7:0]  nSEG,
    output logic [3:0]  nAN,
    output logic        FRAME
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   dig_q;
    logic [3:0]    dp_q;
    logic          lz_q;

    logic          load;
    logic          in_blank;
    logic [3:0]    cur;
    logic          blank_digit;
    logic [6:0]    seg;
    logic [7:0]    seg_n;
    logic [3:0]    an_n;

    assign load = (cnt == '0) && (idx == 2'd0);

    // With BLANK=0 there is no blank phase; generating the constant keeps the
    // comparison against zero out of the netlist.
    generate
        if (BLANK == 0) begin : g_noblank
            assign in_blank = 1'b0;
        end else begin : g_blank
            localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
            assign in_blank = (cnt < BLANK_C);
        end
    endgenerate

    always_comb begin
        cur         = dig_q[3:0];
        blank_digit = 1'b0;
        case (idx)
            2'd0: cur = dig_q[3:0];
            2'd1: cur = dig_q[7:4];
            2'd2: cur = dig_q[11:8];
            2'd3: cur = dig_q[15:12];
            default: cur = dig_q[3:0];
        endcase
        // A digit is a leading zero when it and every digit to its left is 0;
        // digit0 always shows.
        if (lz_q) begin
            case (idx)
                2'd1: blank_digit = (dig_q[15:4] == 12'h000);
                2'd2: blank_digit = (dig_q[15:8] == 8'h00);
                2'd3: blank_digit = (dig_q[15:12] == 4'h0);
                default: blank_digit = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (cur)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1011000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

    always_comb begin
        seg_n = '1;
        an_n  = '1;
        if (!in_blank) begin
            // Blanked leading zeros keep their anode on for uniform duty.
            an_n  = ~(4'b0001 << idx);
            seg_n = {~dp_q[idx], (blank_digit ? 7'b1111111 : seg)};
        end
    end

    always_ff @(posedge CLK100) begin
        if (RST) begin
            cnt   <= '0;
            idx   <= '0;
            dig_q <= '0;
            dp_q  <= '0;
            lz_q  <= 1'b0;
            nSEG  <= '1;
            nAN   <= '1;
            FRAME <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (load) begin
                dig_q <= DIGITS;
                dp_q  <= DP_IN;
                lz_q  <= LZ_EN;
            end
            nSEG  <= seg_n;
            nAN   <= an_n;
            FRAME <= load;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    localparam int SD = 8;
    localparam int BL = 2;

    logic        CLK100 = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] DIGITS = 16'h0000;
    logic [3:0]  DP_IN = 4'b0000;
    logic        LZ_EN = 1'b0;
    logic [7:0]  nSEG, nSEG0;
    logic [3:0]  nAN, nAN0;
    logic        FRAME, FRAME0;

    int checks = 0;
    int failures = 0;
    logic [12:0] sb [$];
    logic [12:0] e;
    logic mon_en = 1'b0;
    logic viol = 1'b0;

    logic [3:0] exp_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK(BL)) dut (
        .CLK100(CLK100), .RST(RST), .DIGITS(DIGITS), .DP_IN(DP_IN),
        .LZ_EN(LZ_EN), .nSEG(nSEG), .nAN(nAN), .FRAME(FRAME));

    seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK(0)) dut0 (
        .CLK100(CLK100), .RST(RST), .DIGITS(DIGITS), .DP_IN(DP_IN),
        .LZ_EN(LZ_EN), .nSEG(nSEG0), .nAN(nAN0), .FRAME(FRAME0));

    always #5 CLK100 = ~CLK100;

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1011000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference model of the BLANK=2 instance: each rising edge pushes the
    // output the DUT must present after that edge.
    int m_cnt = 0;
    int m_idx = 0;
    logic [15:0] m_dig = '0;
    logic [3:0]  m_dp = '0;
    logic        m_lz = 1'b0;

    always @(posedge CLK100) begin : model
        logic [7:0] es;
        logic [3:0] ea;
        logic       ef;
        logic       bl;
        es = 8'hFF;
        ea = 4'hF;
        ef = 1'b0;
        if (RST) begin
            m_cnt = 0; m_idx = 0; m_dig = '0; m_dp = '0; m_lz = 1'b0;
        end else begin
            ef = (m_cnt == 0) && (m_idx == 0);
            if (m_cnt >= BL) begin
                bl = m_lz && (m_idx != 0) && ((m_dig >> (m_idx * 4)) == 16'h0);
                ea[m_idx] = 1'b0;
                es = {~m_dp[m_idx], (bl ? 7'b1111111 : ref_seg(m_dig[m_idx*4 +: 4]))};
            end
            if (ef) begin
                m_dig = DIGITS; m_dp = DP_IN; m_lz = LZ_EN;
            end
            m_cnt = m_cnt + 1;
            if (m_cnt == SD) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end
        end
        sb.push_back({es, ea, ef});
    end

    always @(negedge CLK100) begin
        if (mon_en && (!$onehot0(~nAN) || !$onehot0(~nAN0))) viol = 1'b1;
    end

    task automatic apply_reset(input logic [15:0] d, input logic [3:0] dp, input logic lz);
        @(negedge CLK100);
        RST = 1'b1; DIGITS = d; DP_IN = dp; LZ_EN = lz;
        repeat (2) @(negedge CLK100);
        RST = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        for (int n = 1; n <= 3; n++) begin
            @(negedge CLK100);
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL reset_sb n=%0d queue empty", n); end
            else begin e = sb.pop_front();
                if ({nSEG, nAN, FRAME} !== e) begin failures++; $display("FAIL reset_sb n=%0d got=%b exp=%b", n, {nSEG, nAN, FRAME}, e); end
            end
            checks++;
            if ({nSEG, nAN, FRAME} !== {8'hFF, 4'b1111, 1'b0}) begin
                failures++; $display("FAIL reset_hold n=%0d got=%b exp=%b", n, {nSEG, nAN, FRAME}, {8'hFF, 4'b1111, 1'b0});
            end
        end
        RST = 1'b0;
        mon_en = 1'b1;
        sb.delete();
        for (int n = 1; n <= 9; n++) begin
            @(negedge CLK100);
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL first_sb n=%0d queue empty", n); end
            else begin e = sb.pop_front();
                if ({nSEG, nAN, FRAME} !== e) begin failures++; $display("FAIL first_sb n=%0d got=%b exp=%b", n, {nSEG, nAN, FRAME}, e); end
            end
            checks++;
            if (nAN !== ((n <= 2 || n == 9) ? 4'b1111 : 4'b1110) || FRAME !== (n == 1)) begin
                failures++; $display("FAIL first_frame n=%0d got nAN=%b FRAME=%b", n, nAN, FRAME);
            end
        end
    endtask

    task automatic test_full_scan();
        logic [7:0] xs [4] = '{8'b10011001, 8'b10110000, 8'b00100100, 8'b11111001};
        int s, i;
        apply_reset(16'h1234, 4'b0100, 1'b0);
        for (int n = 1; n <= 64; n++) begin
            @(negedge CLK100);
            s = (n - 1) % SD; i = ((n - 1) / SD) % 4;
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL scan_sb n=%0d queue empty", n); end
            else begin e = sb.pop_front();
                if ({nSEG, nAN, FRAME} !== e) begin failures++; $display("FAIL scan_sb n=%0d got=%b exp=%b", n, {nSEG, nAN, FRAME}, e); end
            end
            checks++;
            if (nSEG !== ((s < BL) ? 8'hFF : xs[i]) || nAN !== ((s < BL) ? 4'b1111 : exp_an[i])
                || FRAME !== ((n - 1) % 32 == 0)) begin
                failures++; $display("FAIL scan_slot n=%0d got=%b/%b/%b", n, nSEG, nAN, FRAME);
            end
        end
    endtask

    task automatic test_leading_zeros();
        int s, i;
        logic [7:0] xs;
        for (int pass = 0; pass < 2; pass++) begin
            apply_reset(16'h0005, 4'b0000, (pass == 0));
            for (int n = 1; n <= 32; n++) begin
                @(negedge CLK100);
                s = (n - 1) % SD; i = ((n - 1) / SD) % 4;
                if (s < BL) xs = 8'hFF;
                else if (i == 0) xs = 8'b10010010;
                else xs = (pass == 0) ? 8'b11111111 : 8'b11000000;
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL lz_sb n=%0d queue empty", n); end
                else begin e = sb.pop_front();
                    if ({nSEG, nAN, FRAME} !== e) begin failures++; $display("FAIL lz_sb lz=%0d n=%0d got=%b exp=%b", 1 - pass, n, {nSEG, nAN, FRAME}, e); end
                end
                checks++;
                if (nSEG !== xs || nAN !== ((s < BL) ? 4'b1111 : exp_an[i])) begin
                    failures++; $display("FAIL lz_slot lz=%0d n=%0d got=%b/%b exp=%b/%b", 1 - pass, n, nSEG, nAN, xs, (s < BL) ? 4'b1111 : exp_an[i]);
                end
            end
        end
    endtask

    task automatic test_frame_coherency();
        int s, i, f;
        logic [7:0] xs;
        apply_reset(16'h0009, 4'b0000, 1'b0);
        for (int n = 1; n <= 96; n++) begin
            @(negedge CLK100);
            s = (n - 1) % SD; i = ((n - 1) / SD) % 4; f = (n - 1) / 32;
            if (s < BL) xs = 8'hFF;
            else if (f == 0) xs = (i == 0) ? 8'b10010000 : 8'b11000000;
            else if (f == 1) xs = (i == 1) ? 8'b11111001 : 8'b11000000;
            else xs = 8'b10000000;
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL coh_sb n=%0d queue empty", n); end
            else begin e = sb.pop_front();
                if ({nSEG, nAN, FRAME} !== e) begin failures++; $display("FAIL coh_sb n=%0d got=%b exp=%b", n, {nSEG, nAN, FRAME}, e); end
            end
            checks++;
            if (nSEG !== xs) begin failures++; $display("FAIL coh_slot n=%0d got=%b exp=%b", n, nSEG, xs); end
            if (n == 18) DIGITS = 16'h0010;
            if (n == 36) DIGITS = 16'h8888;
        end
    endtask

    task automatic test_invalid_blank0();
        int s, i;
        apply_reset(16'hABCD, 4'b1111, 1'b0);
        for (int n = 1; n <= 64; n++) begin
            @(negedge CLK100);
            s = (n - 1) % SD; i = ((n - 1) / SD) % 4;
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL inv_sb n=%0d queue empty", n); end
            else begin e = sb.pop_front();
                if ({nSEG, nAN, FRAME} !== e) begin failures++; $display("FAIL inv_sb n=%0d got=%b exp=%b", n, {nSEG, nAN, FRAME}, e); end
            end
            checks++;
            if (nSEG !== ((s < BL) ? 8'hFF : 8'b01111111)) begin
                failures++; $display("FAIL inv_seg n=%0d got=%b exp=%b", n, nSEG, (s < BL) ? 8'hFF : 8'b01111111);
            end
            // The first post-reset cycle still shows the cleared shadow, so
            // only the anode is fixed there.
            checks++;
            if (nAN0 !== exp_an[i] || FRAME0 !== ((n - 1) % 32 == 0) || (n > 1 && nSEG0 !== 8'b01111111)) begin
                failures++; $display("FAIL blank0 n=%0d got=%b/%b/%b exp_an=%b", n, nSEG0, nAN0, FRAME0, exp_an[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int s, i;
        apply_reset(16'h1234, 4'b0000, 1'b0);
        for (int n = 1; n <= 29; n++) begin
            @(negedge CLK100);
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL mid_sb n=%0d queue empty", n); end
            else begin e = sb.pop_front();
                if ({nSEG, nAN, FRAME} !== e) begin failures++; $display("FAIL mid_sb n=%0d got=%b exp=%b", n, {nSEG, nAN, FRAME}, e); end
            end
        end
        // Model state is now idx=3, cnt=5; reset lands on the next edge.
        RST = 1'b1;
        @(negedge CLK100);
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL mid_rst_sb queue empty"); end
        else begin e = sb.pop_front();
            if ({nSEG, nAN, FRAME} !== e) begin failures++; $display("FAIL mid_rst_sb got=%b exp=%b", {nSEG, nAN, FRAME}, e); end
        end
        checks++;
        if ({nSEG, nAN, FRAME} !== {8'hFF, 4'b1111, 1'b0}) begin
            failures++; $display("FAIL mid_rst got=%b exp=%b", {nSEG, nAN, FRAME}, {8'hFF, 4'b1111, 1'b0});
        end
        RST = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge CLK100);
            s = (n - 1) % SD; i = ((n - 1) / SD) % 4;
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL restart_sb n=%0d queue empty", n); end
            else begin e = sb.pop_front();
                if ({nSEG, nAN, FRAME} !== e) begin failures++; $display("FAIL restart_sb n=%0d got=%b exp=%b", n, {nSEG, nAN, FRAME}, e); end
            end
            checks++;
            if (nAN !== ((s < BL) ? 4'b1111 : exp_an[i]) || FRAME !== (n == 1)) begin
                failures++; $display("FAIL restart n=%0d got nAN=%b FRAME=%b", n, nAN, FRAME);
            end
        end
        checks++;
        if (viol !== 1'b0) begin failures++; $display("FAIL anode_onehot got=%b exp=0", viol); end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_leading_zeros();
        test_frame_coherency();
        test_invalid_blank0();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
